// File: rtl/pulse_width_meter_pkg.sv
// Shared definitions for the pulse width meter and the countdown timeout block:
// FSM encoding and the default counter width.
package pulse_width_meter_pkg;

    localparam int DEFAULT_COUNTER_WIDTH = 8;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_MEASURE = 1'b1
    } meas_state_e;

endpackage

// File: rtl/pulse_width_meter_sync_chain.sv
// Multi-flop synchroniser for a single asynchronous input. Every stage resets to 0,
// so a reset always leaves the chain reporting a low input.
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic srst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        if (gi == 0) begin : g_first
            assign sync_d[gi] = d;
        end else begin : g_rest
            assign sync_d[gi] = sync_q[gi-1];
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pulse_width_meter.sv
// Measures the high time of an asynchronous pulse in clk_in cycles and hands the
// result to a consumer through a one-entry valid/ready holding register.
module pulse_width_meter
    import pulse_width_meter_pkg::*;
#(
    parameter int COUNTER_WIDTH = DEFAULT_COUNTER_WIDTH,
    parameter int SYNC_STAGES   = 2,
    parameter int MIN_WIDTH     = 1
) (
    input  logic                     clk_in,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     sig_in,
    output logic [COUNTER_WIDTH-1:0] width,
    output logic                     width_saturated,
    output logic                     width_valid,
    input  logic                     width_ready,
    output logic                     busy,
    output logic                     overrun,
    input  logic                     clear_overrun
);

    localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = COUNTER_WIDTH'(1);
    // One bit wider so MIN_WIDTH values beyond the counter range discard everything.
    localparam logic [COUNTER_WIDTH:0]   MIN_W   = (COUNTER_WIDTH+1)'(MIN_WIDTH);

    logic sig_s;
    logic sig_d_q;
    logic rise;
    logic push;
    logic pop;

    meas_state_e              state_q, state_d;
    logic [COUNTER_WIDTH-1:0] count_q, count_d;
    logic                     sat_q, sat_d;
    logic [COUNTER_WIDTH-1:0] width_q, width_d;
    logic                     width_sat_q, width_sat_d;
    logic                     valid_q, valid_d;
    logic                     overrun_q, overrun_d;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk  (clk_in),
        .srst (reset),
        .d    (sig_in),
        .q    (sig_s)
    );

    assign rise = sig_s & ~sig_d_q;
    assign pop  = valid_q & width_ready;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        sat_d       = sat_q;
        width_d     = width_q;
        width_sat_d = width_sat_q;
        valid_d     = valid_q;
        overrun_d   = overrun_q;
        push        = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (rise && enable) begin
                    state_d = ST_MEASURE;
                    count_d = CNT_ONE;
                    sat_d   = 1'b0;
                end
            end
            ST_MEASURE: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (sig_s) begin
                    if (count_q == CNT_MAX) begin
                        sat_d = 1'b1;
                    end else begin
                        count_d = count_q + CNT_ONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                    push    = ({1'b0, count_q} >= MIN_W);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Clear first so a drop in the same cycle leaves overrun set.
        if (clear_overrun) begin
            overrun_d = 1'b0;
        end

        if (push) begin
            if (!valid_q || pop) begin
                width_d     = count_q;
                width_sat_d = sat_q;
                valid_d     = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (pop) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            sig_d_q     <= 1'b0;
            state_q     <= ST_IDLE;
            count_q     <= '0;
            sat_q       <= 1'b0;
            width_q     <= '0;
            width_sat_q <= 1'b0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sig_d_q     <= sig_s;
            state_q     <= state_d;
            count_q     <= count_d;
            sat_q       <= sat_d;
            width_q     <= width_d;
            width_sat_q <= width_sat_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign width           = width_q;
    assign width_saturated = width_sat_q;
    assign width_valid     = valid_q;
    assign busy            = (state_q == ST_MEASURE);
    assign overrun         = overrun_q;

endmodule

// File: tb/tb_pulse_width_meter.sv
// Directed bench for pulse_width_meter: three instances (default, 4-bit counter,
// MIN_WIDTH=3) share control inputs and each gets its own sig_in.
module tb_pulse_width_meter;

    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic reset, enable, width_ready, clear_overrun;
    logic sig_a, sig_b, sig_c;

    logic [7:0] width_a;
    logic       sat_a, valid_a, busy_a, ovr_a;
    logic [3:0] width_b;
    logic       sat_b, valid_b, busy_b, ovr_b;
    logic [7:0] width_c;
    logic       sat_c, valid_c, busy_c, ovr_c;

    pulse_width_meter #(.COUNTER_WIDTH(8), .SYNC_STAGES(2), .MIN_WIDTH(1)) dut_a (
        .clk_in(clk_in), .reset(reset), .enable(enable), .sig_in(sig_a),
        .width(width_a), .width_saturated(sat_a), .width_valid(valid_a),
        .width_ready(width_ready), .busy(busy_a), .overrun(ovr_a),
        .clear_overrun(clear_overrun)
    );

    pulse_width_meter #(.COUNTER_WIDTH(4), .SYNC_STAGES(2), .MIN_WIDTH(1)) dut_b (
        .clk_in(clk_in), .reset(reset), .enable(enable), .sig_in(sig_b),
        .width(width_b), .width_saturated(sat_b), .width_valid(valid_b),
        .width_ready(width_ready), .busy(busy_b), .overrun(ovr_b),
        .clear_overrun(clear_overrun)
    );

    pulse_width_meter #(.COUNTER_WIDTH(8), .SYNC_STAGES(2), .MIN_WIDTH(3)) dut_c (
        .clk_in(clk_in), .reset(reset), .enable(enable), .sig_in(sig_c),
        .width(width_c), .width_saturated(sat_c), .width_valid(valid_c),
        .width_ready(width_ready), .busy(busy_c), .overrun(ovr_c),
        .clear_overrun(clear_overrun)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            $display("ok   %s = %0d", name, act);
        end
    endtask

    function automatic logic get_valid(input int sel);
        case (sel)
            0:       return valid_a;
            1:       return valid_b;
            default: return valid_c;
        endcase
    endfunction

    function automatic logic [31:0] get_width(input int sel);
        case (sel)
            0:       return {24'd0, width_a};
            1:       return {28'd0, width_b};
            default: return {24'd0, width_c};
        endcase
    endfunction

    function automatic logic get_sat(input int sel);
        case (sel)
            0:       return sat_a;
            1:       return sat_b;
            default: return sat_c;
        endcase
    endfunction

    task automatic drive_sig(input int sel, input logic v);
        case (sel)
            0:       sig_a = v;
            1:       sig_b = v;
            default: sig_c = v;
        endcase
    endtask

    // Drives n high cycles; returns at the negedge where sig_in goes low.
    task automatic pulse(input int sel, input int n);
        @(negedge clk_in);
        drive_sig(sel, 1'b1);
        repeat (n) @(negedge clk_in);
        drive_sig(sel, 1'b0);
    endtask

    // lat = number of negedges until width_valid, or -1 if the bound expires.
    task automatic wait_valid(input int sel, input int limit, output int lat);
        lat = -1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk_in);
            if (get_valid(sel)) begin
                lat = i;
                break;
            end
        end
    endtask

    typedef struct {
        int sel;
        int high;
        int exp_w;
        int exp_sat;
    } vec_t;

    vec_t vecs[12];
    int   lat;
    int   results[$];

    initial begin
        vecs[0]  = '{0,   5,   5, 0};
        vecs[1]  = '{0,   1,   1, 0};
        vecs[2]  = '{0,   2,   2, 0};
        vecs[3]  = '{0,  17,  17, 0};
        vecs[4]  = '{0, 255, 255, 0};
        vecs[5]  = '{0, 256, 255, 1};
        vecs[6]  = '{0, 300, 255, 1};
        vecs[7]  = '{1,  15,  15, 0};
        vecs[8]  = '{1,  16,  15, 1};
        vecs[9]  = '{1,  40,  15, 1};
        vecs[10] = '{2,   3,   3, 0};
        vecs[11] = '{2,   4,   4, 0};

        reset = 1'b1; enable = 1'b1; width_ready = 1'b1; clear_overrun = 1'b0;
        sig_a = 1'b0; sig_b = 1'b0; sig_c = 1'b0;
        repeat (3) @(negedge clk_in);
        check("rst_width", {24'd0, width_a}, 0);
        check("rst_valid", {31'd0, valid_a}, 0);
        check("rst_overrun", {31'd0, ovr_a}, 0);
        check("rst_busy", {31'd0, busy_a}, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk_in);

        // Single pulses: width, saturation, latency and one-cycle valid with ready=1.
        for (int i = 0; i < 12; i++) begin
            pulse(vecs[i].sel, vecs[i].high);
            wait_valid(vecs[i].sel, 12, lat);
            check($sformatf("vec%0d_latency", i), lat, 3);
            check($sformatf("vec%0d_width", i), get_width(vecs[i].sel), vecs[i].exp_w);
            check($sformatf("vec%0d_sat", i), {31'd0, get_sat(vecs[i].sel)}, vecs[i].exp_sat);
            @(negedge clk_in);
            check($sformatf("vec%0d_valid_drop", i), {31'd0, get_valid(vecs[i].sel)}, 0);
            repeat (3) @(negedge clk_in);
        end

        // Glitch filter: 1 and 2 cycle pulses vanish, 3 cycles is reported.
        pulse(2, 1);
        wait_valid(2, 10, lat);
        check("glitch1_discarded", lat, -1);
        pulse(2, 2);
        wait_valid(2, 10, lat);
        check("glitch2_discarded", lat, -1);
        pulse(2, 3);
        wait_valid(2, 10, lat);
        check("minw3_width", get_width(2), 3);

        // Holding register full: second result is dropped, overrun sticks.
        @(negedge clk_in);
        width_ready = 1'b0;
        pulse(0, 4);
        wait_valid(0, 12, lat);
        check("hold_width", get_width(0), 4);
        repeat (2) @(negedge clk_in);
        pulse(0, 6);
        repeat (6) @(negedge clk_in);
        check("hold_valid", {31'd0, valid_a}, 1);
        check("hold_kept", get_width(0), 4);
        check("hold_overrun", {31'd0, ovr_a}, 1);
        width_ready = 1'b1;
        @(negedge clk_in);
        check("pop_valid", {31'd0, valid_a}, 0);
        check("pop_width_kept", get_width(0), 4);
        check("pop_overrun_sticky", {31'd0, ovr_a}, 1);
        clear_overrun = 1'b1;
        @(negedge clk_in);
        clear_overrun = 1'b0;
        check("clear_overrun", {31'd0, ovr_a}, 0);

        // Push and pop on the same edge: new result replaces old, no overrun.
        width_ready = 1'b0;
        pulse(0, 4);
        wait_valid(0, 12, lat);
        check("pp_first", get_width(0), 4);
        pulse(0, 5);
        repeat (2) @(negedge clk_in);
        width_ready = 1'b1;
        @(negedge clk_in);
        check("pp_valid", {31'd0, valid_a}, 1);
        check("pp_width", get_width(0), 5);
        check("pp_overrun", {31'd0, ovr_a}, 0);
        @(negedge clk_in);
        check("pp_drained", {31'd0, valid_a}, 0);

        // Back-to-back: 3 high, 1 low, 7 high.
        repeat (2) @(negedge clk_in);
        results.delete();
        fork
            begin
                @(negedge clk_in);
                sig_a = 1'b1;
                repeat (3) @(negedge clk_in);
                sig_a = 1'b0;
                @(negedge clk_in);
                sig_a = 1'b1;
                repeat (7) @(negedge clk_in);
                sig_a = 1'b0;
            end
            begin
                for (int i = 0; i < 30; i++) begin
                    @(negedge clk_in);
                    if (valid_a) results.push_back(int'(width_a));
                end
            end
        join
        check("b2b_count", results.size(), 2);
        if (results.size() >= 2) begin
            check("b2b_first", results[0], 3);
            check("b2b_second", results[1], 7);
        end
        check("b2b_overrun", {31'd0, ovr_a}, 0);

        // Enable dropped mid-pulse; re-enabling while still high must not start a measurement.
        @(negedge clk_in);
        sig_a = 1'b1;
        repeat (5) @(negedge clk_in);
        check("abort_busy_before", {31'd0, busy_a}, 1);
        enable = 1'b0;
        @(negedge clk_in);
        check("abort_busy_after", {31'd0, busy_a}, 0);
        enable = 1'b1;
        repeat (6) @(negedge clk_in);
        check("already_high_ignored", {31'd0, busy_a}, 0);
        sig_a = 1'b0;
        wait_valid(0, 10, lat);
        check("abort_no_result", lat, -1);

        // Reset mid-pulse with a held result and overrun pending.
        width_ready = 1'b0;
        pulse(0, 6);
        wait_valid(0, 12, lat);
        pulse(0, 3);
        repeat (5) @(negedge clk_in);
        check("pre_reset_overrun", {31'd0, ovr_a}, 1);
        @(negedge clk_in);
        sig_a = 1'b1;
        repeat (5) @(negedge clk_in);
        check("pre_reset_busy", {31'd0, busy_a}, 1);
        reset = 1'b1;
        enable = 1'b0;
        @(negedge clk_in);
        check("midrst_busy", {31'd0, busy_a}, 0);
        check("midrst_valid", {31'd0, valid_a}, 0);
        check("midrst_width", {24'd0, width_a}, 0);
        check("midrst_sat", {31'd0, sat_a}, 0);
        check("midrst_overrun", {31'd0, ovr_a}, 0);
        reset = 1'b0;
        sig_a = 1'b0;
        repeat (4) @(negedge clk_in);
        enable = 1'b1;
        width_ready = 1'b1;
        wait_valid(0, 10, lat);
        check("midrst_no_result", lat, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
